// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: conditions ps2c/ps2d, deserializes 11-bit frames,
// folds the F0/E0 prefixes into flags and presents one event per key action.
module ps2_kb_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rd_key,
    output logic [7:0] key_code,
    output logic       key_release,
    output logic       key_ext,
    output logic       key_valid,
    output logic       parity_err,
    output logic       overrun
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    // Frame layout in the shift register: [7:0] data, [8] odd parity, [9] stop.
    function automatic logic frame_ok(input logic [9:0] frame);
        return frame[9] & (^frame[8:0]);
    endfunction

    logic                  ps2c_meta_q, ps2c_sync_q, ps2d_meta_q, ps2d_sync_q;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  fclk_q, fclk_d;
    logic                  fall_s;
    state_t                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [9:0]            shift_q, shift_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  brk_pend_q, ext_pend_q;
    logic                  load_s, perr_s, set_brk_s, set_ext_s;
    logic [7:0]            key_code_q;
    logic                  key_release_q, key_ext_q, key_valid_q;
    logic                  parity_err_q, overrun_q;

    // Two-flop synchronizers; idle-high lines so reset to 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2c_meta_q <= 1'b1;
            ps2c_sync_q <= 1'b1;
            ps2d_meta_q <= 1'b1;
            ps2d_sync_q <= 1'b1;
        end else begin
            ps2c_meta_q <= ps2c;
            ps2c_sync_q <= ps2c_meta_q;
            ps2d_meta_q <= ps2d;
            ps2d_sync_q <= ps2d_meta_q;
        end
    end

    // Glitch filter: level changes only once FILTER_LEN samples agree.
    always_comb begin
        filt_d = {filt_q[FILTER_LEN-2:0], ps2c_sync_q};
        if (&filt_q) begin
            fclk_d = 1'b1;
        end else if (~|filt_q) begin
            fclk_d = 1'b0;
        end else begin
            fclk_d = fclk_q;
        end
    end

    assign fall_s = fclk_q & ~fclk_d;

    // Filter shift register and filtered clock level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= {FILTER_LEN{1'b1}};
            fclk_q <= 1'b1;
        end else begin
            filt_q <= filt_d;
            fclk_q <= fclk_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a falling edge takes priority over timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fall_s && !ps2d_sync_q) begin
                    state_d = S_RECV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RECV: begin
                if (fall_s && (bit_cnt_q == 4'd1)) begin
                    state_d = S_CHECK;
                end else if (!fall_s && (tmo_q == TO_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RECV;
                end
            end
            S_CHECK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: classify the completed frame during CHECK.
    always_comb begin
        load_s    = 1'b0;
        perr_s    = 1'b0;
        set_brk_s = 1'b0;
        set_ext_s = 1'b0;
        case (state_q)
            S_CHECK: begin
                if (!frame_ok(shift_q)) begin
                    perr_s = 1'b1;
                end else if (shift_q[7:0] == 8'hF0) begin
                    set_brk_s = 1'b1;
                end else if (shift_q[7:0] == 8'hE0) begin
                    set_ext_s = 1'b1;
                end else begin
                    load_s = 1'b1;
                end
            end
            default: begin
                load_s    = 1'b0;
                perr_s    = 1'b0;
                set_brk_s = 1'b0;
                set_ext_s = 1'b0;
            end
        endcase
    end

    // Receive datapath next-state: bit counter, shifter, inactivity timer.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = {TW{1'b0}};
        if ((state_q == S_IDLE) && fall_s && !ps2d_sync_q) begin
            bit_cnt_d = 4'd10;
        end else if ((state_q == S_RECV) && fall_s) begin
            bit_cnt_d = bit_cnt_q - 4'd1;
            shift_d   = {ps2d_sync_q, shift_q[9:1]};
        end else begin
            bit_cnt_d = bit_cnt_q;
            shift_d   = shift_q;
        end
        if ((state_q == S_RECV) && !fall_s && (tmo_q != TO_LAST)) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = {TW{1'b0}};
        end
    end

    // Receive datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q <= 4'd0;
            shift_q   <= 10'd0;
            tmo_q     <= {TW{1'b0}};
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
        end
    end

    // Prefix flags survive a timeout but are dropped by any event or bad frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
        end else if (load_s || perr_s) begin
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
        end else begin
            brk_pend_q <= brk_pend_q | set_brk_s;
            ext_pend_q <= ext_pend_q | set_ext_s;
        end
    end

    // Event registers and one-entry valid/read handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_code_q    <= 8'd0;
            key_release_q <= 1'b0;
            key_ext_q     <= 1'b0;
            key_valid_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            parity_err_q <= perr_s;
            overrun_q    <= load_s & key_valid_q & ~rd_key;
            if (load_s) begin
                key_code_q    <= shift_q[7:0];
                key_release_q <= brk_pend_q;
                key_ext_q     <= ext_pend_q;
                key_valid_q   <= 1'b1;
            end else if (rd_key) begin
                key_valid_q <= 1'b0;
            end
        end
    end

    assign key_code    = key_code_q;
    assign key_release = key_release_q;
    assign key_ext     = key_ext_q;
    assign key_valid   = key_valid_q;
    assign parity_err  = parity_err_q;
    assign overrun     = overrun_q;

endmodule
